// File: rtl/sbg_count_param.sv
// sbg_count_param: parametrised baseball pitch scorekeeper with registered counts and event pulses
module sbg_count_param #(
  parameter int STRIKE_LIMIT = 3,
  parameter int BALL_LIMIT = 4,
  parameter int OUT_LIMIT = 3,
  parameter int RUN_W = 8,
  parameter int INN_W = 4,
  localparam int SW = $clog2(STRIKE_LIMIT),
  localparam int BW = $clog2(BALL_LIMIT),
  localparam int OW = $clog2(OUT_LIMIT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pitch_valid,
  input  logic [1:0]       XY,
  output logic [SW-1:0]    strike_cnt,
  output logic [BW-1:0]    ball_cnt,
  output logic [OW-1:0]    out_cnt,
  output logic [2:0]       bases,
  output logic [RUN_W-1:0] runs,
  output logic [INN_W-1:0] inning,
  output logic             strikeout,
  output logic             walk,
  output logic             hit,
  output logic             run_scored,
  output logic             inning_end
);
  localparam logic [SW-1:0] S_MAX = SW'(STRIKE_LIMIT - 1);
  localparam logic [BW-1:0] B_MAX = BW'(BALL_LIMIT - 1);
  localparam logic [OW-1:0] O_MAX = OW'(OUT_LIMIT - 1);
  logic [SW-1:0]    n_strike;
  logic [BW-1:0]    n_ball;
  logic [OW-1:0]    n_out;
  logic [2:0]       n_bases;
  logic [RUN_W-1:0] n_runs;
  logic [INN_W-1:0] n_inning;
  logic             n_so, n_walk, n_hit, n_rs, n_ie, rec_out;
  // next state and pulses from the current pitch; an out ending the half-inning overrides bases and counts
  always_comb begin
    n_strike = strike_cnt;
    n_ball = ball_cnt;
    n_out = out_cnt;
    n_bases = bases;
    n_runs = runs;
    n_inning = inning;
    n_so = 1'b0;
    n_walk = 1'b0;
    n_hit = 1'b0;
    n_rs = 1'b0;
    n_ie = 1'b0;
    rec_out = 1'b0;
    if (pitch_valid) begin
      if (XY == 2'b00) begin
        n_hit = 1'b1;
        n_strike = '0;
        n_ball = '0;
        n_bases = {bases[1:0], 1'b1};
        n_rs = bases[2];
      end else if (XY == 2'b01) begin
        n_strike = '0;
        n_ball = '0;
        rec_out = 1'b1;
      end else if (XY == 2'b10) begin
        if (ball_cnt == B_MAX) begin
          n_walk = 1'b1;
          n_strike = '0;
          n_ball = '0;
          n_bases = bases[0] ? (bases[1] ? 3'b111 : bases | 3'b011) : bases | 3'b001;
          n_rs = &bases;
        end else n_ball = ball_cnt + 1'b1;
      end else if (strike_cnt == S_MAX) begin
        n_so = 1'b1;
        n_strike = '0;
        n_ball = '0;
        rec_out = 1'b1;
      end else n_strike = strike_cnt + 1'b1;
      n_runs = (n_rs && runs != '1) ? runs + 1'b1 : runs;
      if (rec_out) begin
        if (out_cnt == O_MAX) begin
          n_ie = 1'b1;
          n_out = '0;
          n_bases = '0;
          n_inning = inning + 1'b1;
          n_strike = '0;
          n_ball = '0;
        end else n_out = out_cnt + 1'b1;
      end
    end
  end
  // register all state and pulses; reset clears everything without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strike_cnt <= '0;
      ball_cnt <= '0;
      out_cnt <= '0;
      bases <= '0;
      runs <= '0;
      inning <= '0;
      strikeout <= 1'b0;
      walk <= 1'b0;
      hit <= 1'b0;
      run_scored <= 1'b0;
      inning_end <= 1'b0;
    end else begin
      strike_cnt <= n_strike;
      ball_cnt <= n_ball;
      out_cnt <= n_out;
      bases <= n_bases;
      runs <= n_runs;
      inning <= n_inning;
      strikeout <= n_so;
      walk <= n_walk;
      hit <= n_hit;
      run_scored <= n_rs;
      inning_end <= n_ie;
    end
  end
endmodule
